// File: rtl/bus_ctrl_pkg.sv
// Shared types for the bidirectional bus turnaround controller.
// Holds the FSM state encoding, the side encoding and the turn counter width.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, DRV_A, DRV_B, TURN} state_t;
  typedef enum logic {SIDE_A, SIDE_B} side_t;

  localparam int TURN_CYCLES_DEF = 2;
  localparam int TURN_W          = $clog2(TURN_CYCLES_DEF + 1);

  // Turn counter width for a given gap length; never below one bit.
  function automatic int turn_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bus_rr_arb2.sv
// Two-way round-robin picker: on a tie the side that did not own the bus last wins.
// o_gnt is one-hot, bit 0 = side A, bit 1 = side B; all zero when nobody asks.
module bus_rr_arb2
  import bus_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  side_t      i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == SIDE_A) ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/bus_turnaround_ctrl.sv
// Sequencer for a shared bidirectional bus: grants bursts to side A or B, drives the
// per-side output enables and inserts a both-low turnaround gap after every unchained burst.
module bus_turnaround_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_req,
  input  logic [LEN_W-1:0] a_len,
  input  logic             b_req,
  input  logic [LEN_W-1:0] b_len,
  output logic             a_gnt,
  output logic             a_done,
  output logic             b_gnt,
  output logic             b_done,
  output logic             oe_a,
  output logic             oe_b,
  output logic             busy,
  output logic             turn,
  output state_t           dbg_state
);

  localparam int             TCW       = turn_w(TURN_CYCLES);
  localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYCLES - 1);

  state_t           r_state;
  side_t            r_last;
  logic [LEN_W-1:0] r_cnt;
  logic [TCW-1:0]   r_tcnt;

  logic [1:0]       w_pick;
  logic             w_own_req;
  logic             w_oth_req;
  logic [LEN_W-1:0] w_own_len;
  logic             w_chain;

  bus_rr_arb2 u_arb (
    .i_req  ({b_req, a_req}),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // A burst chains only when its owner asks again and the other side is silent.
  always_comb begin
    w_own_req = (r_state == DRV_A) ? a_req : b_req;
    w_oth_req = (r_state == DRV_A) ? b_req : a_req;
    w_own_len = (r_state == DRV_A) ? a_len : b_len;
    w_chain   = (r_cnt == '0) && w_own_req && !w_oth_req;
  end

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_last  <= SIDE_B;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      a_gnt   <= 1'b0;
      a_done  <= 1'b0;
      b_gnt   <= 1'b0;
      b_done  <= 1'b0;
      oe_a    <= 1'b0;
      oe_b    <= 1'b0;
      busy    <= 1'b0;
      turn    <= 1'b0;
    end else begin
      a_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_gnt  <= 1'b0;
      b_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick[0]) begin
            r_state <= DRV_A;
            r_last  <= SIDE_A;
            r_cnt   <= a_len;
            a_gnt   <= 1'b1;
            a_done  <= (a_len == '0);
            oe_a    <= 1'b1;
            busy    <= 1'b1;
          end else if (w_pick[1]) begin
            r_state <= DRV_B;
            r_last  <= SIDE_B;
            r_cnt   <= b_len;
            b_gnt   <= 1'b1;
            b_done  <= (b_len == '0);
            oe_b    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DRV_A, DRV_B: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - LEN_W'(1);
            a_done <= (r_state == DRV_A) && (r_cnt == LEN_W'(1));
            b_done <= (r_state == DRV_B) && (r_cnt == LEN_W'(1));
          end else if (w_chain) begin
            r_cnt  <= w_own_len;
            a_gnt  <= (r_state == DRV_A);
            b_gnt  <= (r_state == DRV_B);
            a_done <= (r_state == DRV_A) && (w_own_len == '0);
            b_done <= (r_state == DRV_B) && (w_own_len == '0);
          end else begin
            r_state <= TURN;
            r_tcnt  <= TURN_LOAD;
            oe_a    <= 1'b0;
            oe_b    <= 1'b0;
            turn    <= 1'b1;
          end
        end
        TURN: begin
          if (r_tcnt == '0) begin
            r_state <= IDLE;
            turn    <= 1'b0;
            busy    <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt - TCW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
